col2im: RTL and testbench
=========================

// Module: col2im
// PURPOSE
//   Inverse of im2col. Reads the systolic-array result matrix Y from the shared
//   word-addressed memory and writes it back as a channel-major feature map.
//   Y is stored pixel-major: element (p,k) at SRC_BASE + p*K + k.
//   The block writes it to DST_BASE + k*H*W + p, one word per cycle.
//   It sits after the systolic writeback and uses the same memory port protocol
//   as im2col, so the next layer's im2col can read the map directly.
// PARAMETERS
//   IMG_W       3            output map width W
//   IMG_H       3            output map height H; M = IMG_H*IMG_W pixels
//   FILTER_NUM  2            output channels K
//   DATA_WIDTH  32           word width
//   ADDR_WIDTH  32           memory address width
//   SRC_BASE    32'h00003000 base address of Y (pixel-major)
//   DST_BASE    32'h00004000 base address of the feature map (channel-major)
//   RELU_EN     0            1: each written word = (signed data_rd < 0) ? 0 : data_rd
// PORTS
//   clk        in   1           clock; all state changes on posedge
//   rst_n      in   1           asynchronous, active-low reset
//   start      in   1           1-cycle pulse; sampled only in IDLE or DONE
//   data_rd    in   DATA_WIDTH  memory read data = mem[addr_rd] from the previous edge
//   addr_rd    out  ADDR_WIDTH  registered read address
//   addr_wr    out  ADDR_WIDTH  registered write address
//   data_wr    out  DATA_WIDTH  write data; combinational from data_rd (plus ReLU)
//   mem_wr_en  out  1           registered write strobe; memory writes on posedge
//   busy       out  1           high in RUN and DRAIN
//   done       out  1           high in DONE; cleared by start or reset
// BEHAVIOUR
//   Reset state (async, any cycle, including mid-run):
//     state=IDLE, addr_rd=SRC_BASE, addr_wr=0, mem_wr_en=0, busy=0, done=0.
//     All counters and valid flags are cleared.
//   FSM: IDLE -start-> RUN -last read issued-> DRAIN -last write-> DONE -start-> RUN.
//     start in RUN or DRAIN is ignored.
//     start in DONE clears done and restarts exactly as from IDLE.
//   Edge numbering: start is sampled at edge 0. T = M*K.
//     Edge 0: addr_rd <= SRC_BASE; state <= RUN.
//     Edge n, 1<=n<T: addr_rd <= SRC_BASE+n. addr_rd is linear; no wrap inside SRC.
//     Edge n+1: memory returns element n on data_rd.
//     Edge n+1: mem_wr_en <= 1 and addr_wr <= dst(n).
//     Edge n+2: element n is written.
//     Throughput is 1 word/cycle with no bubbles.
//   Destination counters: p (pixel, 0..M-1) outer, k (channel, 0..K-1) inner.
//     dst = DST_BASE + k*M + p.
//     Incremental update: +M per step. When k==K-1, wrap to DST_BASE + p + 1.
//     No multiplier is needed.
//   RUN -> DRAIN at edge T-1, once the last address is issued.
//   DRAIN -> DONE at edge T+2. Final write occurs at edge T+1; done rises at edge T+2.
//   mem_wr_en <= 0 at edge T+1. It is high for exactly T consecutive cycles.
//   Data path: plain pass-through, or a signed ReLU when RELU_EN=1.
//     No width change, no saturation.
//   The SRC and DST regions must not overlap; this is not checked.
//   Degenerate case M*K==1: write at edge 2, done at edge 3.
// TESTING
//   1 Defaults, Y(p,k)=100*p+k preloaded, start pulse.
//     -> mem[0x4000+k*9+p]=100*p+k for all 18 words.
//     -> done rises 20 cycles after the start edge; mem_wr_en is high for 18 cycles.
//   2 RELU_EN=1, Y(p,k)=(p odd)? -p : p.
//     -> odd pixels written as 0, even pixels as p; source region unchanged.
//   3 Assert rst_n low at the 5th write.
//     -> outputs reach reset values immediately; no further writes.
//     -> a new start rewrites all 18 words correctly.
//   4 Pulse start again in RUN at cycle 3.
//     -> ignored; identical write trace and done timing to test 1.
//   5 In DONE, pulse start with new Y.
//     -> done drops next edge; second pass completes in 20 cycles with new data.
//   6 IMG_W=IMG_H=1, FILTER_NUM=1.
//     -> single write to DST_BASE at edge 2; done at edge 3.

Source files
------------

// File: rtl/col2im_if.sv
// col2im control and memory port bundle.
// The master side (col2im) issues read/write addresses and write strobes.
// The slave side (memory plus controller) returns read data and pulses start.
interface col2im_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  mem_wr_en;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, data_rd,
    output addr_rd, addr_wr, data_wr, mem_wr_en, busy, done
  );

  modport slave (
    output start, data_rd,
    input  addr_rd, addr_wr, data_wr, mem_wr_en, busy, done
  );
endinterface

// File: rtl/col2im.sv
// col2im: turns the pixel-major result matrix Y (element (p,k) at SRC_BASE + p*K + k)
// into a channel-major feature map (element (p,k) at DST_BASE + k*M + p).
// Source words are read linearly, one per cycle. Each word returns one cycle
// after its address is issued and is written one cycle after that.
// Destination addresses are stepped incrementally, so no multiplier is needed.
module col2im #(
  parameter int                    IMG_W      = 3,
  parameter int                    IMG_H      = 3,
  parameter int                    FILTER_NUM = 2,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = 32'h0000_3000,
  parameter logic [ADDR_WIDTH-1:0] DST_BASE   = 32'h0000_4000,
  parameter bit                    RELU_EN    = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  col2im_if.master  bus
);

  localparam int M     = IMG_W * IMG_H;
  localparam int K     = FILTER_NUM;
  localparam int T     = M * K;
  localparam int CNT_W = (T > 1) ? $clog2(T) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  // The read counter holds n-1 while address n is being issued.
  // Reaching T-2 therefore means the last source address goes out on this edge.
  localparam logic [CNT_W-1:0]      RD_PENULT = (T > 1) ? CNT_W'(T - 2) : '0;
  localparam logic [KW-1:0]         K_LAST    = KW'(K - 1);
  localparam logic [ADDR_WIDTH-1:0] M_STEP    = ADDR_WIDTH'(M);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addrRd;
  logic [ADDR_WIDTH-1:0] r_addrWr;
  logic                  r_wrEn;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_W-1:0]      r_rdCnt;
  logic                  r_issued;
  logic [KW-1:0]         r_k;
  logic [ADDR_WIDTH-1:0] r_dstAddr;
  logic [ADDR_WIDTH-1:0] r_pixAddr;
  logic [DATA_WIDTH-1:0] w_dataWr;

  // Sequencer, read issue and destination stepping.
  // r_issued marks a read in flight; it becomes a write strobe one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addrRd  <= SRC_BASE;
      r_addrWr  <= '0;
      r_wrEn    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rdCnt   <= '0;
      r_issued  <= 1'b0;
      r_k       <= '0;
      r_dstAddr <= DST_BASE;
      r_pixAddr <= DST_BASE;
    end else begin
      r_wrEn <= r_issued;
      if (r_issued) begin
        r_addrWr <= r_dstAddr;
        if (r_k == K_LAST) begin
          r_k       <= '0;
          r_pixAddr <= r_pixAddr + ADDR_WIDTH'(1);
          r_dstAddr <= r_pixAddr + ADDR_WIDTH'(1);
        end else begin
          r_k       <= r_k + KW'(1);
          r_dstAddr <= r_dstAddr + M_STEP;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_addrRd  <= SRC_BASE;
            r_rdCnt   <= '0;
            r_issued  <= 1'b1;
            r_k       <= '0;
            r_dstAddr <= DST_BASE;
            r_pixAddr <= DST_BASE;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= (T == 1) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          r_addrRd <= r_addrRd + ADDR_WIDTH'(1);
          r_rdCnt  <= r_rdCnt + CNT_W'(1);
          r_issued <= 1'b1;
          if (r_rdCnt == RD_PENULT) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_issued <= 1'b0;
          if (!r_issued && !r_wrEn) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write data follows read data directly.
  // With ReLU enabled, negative words are written as zero.
  always_comb begin
    w_dataWr = bus.data_rd;
    if (RELU_EN && bus.data_rd[DATA_WIDTH-1]) begin
      w_dataWr = '0;
    end
  end

  assign bus.addr_rd   = r_addrRd;
  assign bus.addr_wr   = r_addrWr;
  assign bus.data_wr   = w_dataWr;
  assign bus.mem_wr_en = r_wrEn;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_col2im.sv
// Testbench for col2im.
// Three instances share one clock and reset:
//   dut0 uses the default parameters.
//   dut1 has ReLU enabled.
//   dut2 has a 1x1 map with a single channel.
// Each instance has its own word memory, driven from the single stimulus thread.
module tb_col2im;

  localparam logic [31:0] SRC = 32'h0000_3000;
  localparam logic [31:0] DST = 32'h0000_4000;

  logic clk;
  logic rst_n;

  col2im_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  col2im_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  col2im_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  col2im dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  col2im #(.RELU_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  col2im #(.IMG_W(1), .IMG_H(1), .FILTER_NUM(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [31:0] oAddrRd [3];
  logic [31:0] oAddrWr [3];
  logic [31:0] oDataWr [3];
  logic        oWrEn   [3];
  logic        oBusy   [3];
  logic        oDone   [3];

  assign oAddrRd[0] = bus0.addr_rd;  assign oAddrRd[1] = bus1.addr_rd;  assign oAddrRd[2] = bus2.addr_rd;
  assign oAddrWr[0] = bus0.addr_wr;  assign oAddrWr[1] = bus1.addr_wr;  assign oAddrWr[2] = bus2.addr_wr;
  assign oDataWr[0] = bus0.data_wr;  assign oDataWr[1] = bus1.data_wr;  assign oDataWr[2] = bus2.data_wr;
  assign oWrEn[0]   = bus0.mem_wr_en; assign oWrEn[1]  = bus1.mem_wr_en; assign oWrEn[2]  = bus2.mem_wr_en;
  assign oBusy[0]   = bus0.busy;     assign oBusy[1]    = bus1.busy;     assign oBusy[2]    = bus2.busy;
  assign oDone[0]   = bus0.done;     assign oDone[1]    = bus1.done;     assign oDone[2]    = bus2.done;

  // Memory images, the source values each pass should reproduce, and the write trace.
  logic [31:0] mem     [3][256];
  logic [31:0] srcVal  [3][32];
  logic [31:0] wrAddr  [3][32];
  int          wrEdge  [3][32];
  int          wrCnt   [3];
  int          wrEnCyc [3];
  int          doneEdge [3];
  int          startEdge [3];
  logic        prevDone [3];
  int          cyc;
  int          nChecks;
  int          nPass;
  int          nFail;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Folds source (0x3000..) and destination (0x4000..) windows into one small array.
  function automatic int idx(input logic [31:0] a);
    logic [7:0] i;
    i = {a[14], a[6:0]};
    return int'(i);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle.
  // Memory acts on the outputs as they stood just before the edge.
  // Monitors sample #1 after the edge.
  task automatic tick();
    logic [31:0] aw [3];
    logic [31:0] dw [3];
    logic [31:0] ar [3];
    logic        we [3];
    int          e;
    for (int d = 0; d < 3; d++) begin
      aw[d] = oAddrWr[d];
      dw[d] = oDataWr[d];
      ar[d] = oAddrRd[d];
      we[d] = oWrEn[d];
    end
    @(posedge clk);
    e = cyc;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (we[d]) begin
        mem[d][idx(aw[d])] = dw[d];
        if (wrCnt[d] < 32) begin
          wrAddr[d][wrCnt[d]] = aw[d];
          wrEdge[d][wrCnt[d]] = e;
        end
        wrCnt[d]++;
      end
    end
    bus0.data_rd = mem[0][idx(ar[0])];
    bus1.data_rd = mem[1][idx(ar[1])];
    bus2.data_rd = mem[2][idx(ar[2])];
    #1;
    for (int d = 0; d < 3; d++) begin
      if (oWrEn[d]) wrEnCyc[d]++;
      if (oDone[d] && !prevDone[d]) doneEdge[d] = e;
      prevDone[d] = oDone[d];
    end
  endtask

  task automatic setStart(input int d, input logic v);
    case (d)
      0: bus0.start = v;
      1: bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  // Start pulse; the edge inside this tick is edge 0 of the pass.
  task automatic applyStimulus(input int d);
    setStart(d, 1'b1);
    startEdge[d] = cyc;
    tick();
    setStart(d, 1'b0);
  endtask

  task automatic clearLog(input int d);
    wrCnt[d]    = 0;
    wrEnCyc[d]  = 0;
    doneEdge[d] = -1000;
  endtask

  task automatic loadSrc(input int d, input int n, input logic [31:0] v);
    mem[d][idx(SRC + 32'(n))] = v;
    srcVal[d][n] = v;
  endtask

  task automatic clearDst(input int d, input int t);
    for (int n = 0; n < t; n++) mem[d][idx(DST + 32'(n))] = 32'hDEAD_BEEF;
  endtask

  task automatic waitDone(input int d, input string tag);
    int guard;
    guard = 0;
    while (!oDone[d] && guard < 60) begin
      tick();
      guard++;
    end
    checkOutput({tag, "_done_seen"}, {31'b0, oDone[d]}, 32'd1);
  endtask

  // Reference:
  //   element n of the pixel-major source is pixel p = n / K, channel k = n % K.
  //   It belongs at DST + k*M + p and is the n-th write, landing at edge n+2.
  //   done rises at edge T+2; the write strobe is high for T cycles.
  task automatic checkPass(input int d, input int m, input int k, input bit relu, input string tag);
    int          t;
    int          p;
    int          kk;
    logic [31:0] a;
    logic [31:0] v;
    t = m * k;
    checkOutput({tag, "_done_edge"}, 32'(doneEdge[d] - startEdge[d]), 32'(t + 2));
    checkOutput({tag, "_wr_count"}, 32'(wrCnt[d]), 32'(t));
    checkOutput({tag, "_wren_cycles"}, 32'(wrEnCyc[d]), 32'(t));
    for (int n = 0; n < t; n++) begin
      p  = n / k;
      kk = n % k;
      a  = DST + 32'(kk * m + p);
      v  = srcVal[d][n];
      if (relu && $signed(v) < 0) v = 32'd0;
      checkOutput($sformatf("%s_mem%0d", tag, n), mem[d][idx(a)], v);
      if (n < wrCnt[d] && n < 32) begin
        checkOutput($sformatf("%s_wraddr%0d", tag, n), wrAddr[d][n], a);
        checkOutput($sformatf("%s_wredge%0d", tag, n), 32'(wrEdge[d][n] - startEdge[d]), 32'(n + 2));
      end
    end
  endtask

  // Directed sequence of scenarios with randomized data.
  initial begin
    int guard;
    nChecks = 0;
    nPass   = 0;
    nFail   = 0;
    cyc     = 0;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 256; i++) mem[d][i] = 32'd0;
      clearLog(d);
      prevDone[d]  = 1'b0;
      startEdge[d] = 0;
    end
    bus0.start = 1'b0;  bus1.start = 1'b0;  bus2.start = 1'b0;
    bus0.data_rd = '0;  bus1.data_rd = '0;  bus2.data_rd = '0;
    rst_n = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_addr_rd", oAddrRd[0], SRC);
    checkOutput("rst_addr_wr", oAddrWr[0], 32'd0);
    checkOutput("rst_wr_en", {31'b0, oWrEn[0]}, 32'd0);
    checkOutput("rst_busy", {31'b0, oBusy[0]}, 32'd0);
    checkOutput("rst_done", {31'b0, oDone[0]}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Y(p,k) = 100*p + k.
    $display("[TB] test 1: default pass");
    for (int n = 0; n < 18; n++) loadSrc(0, n, 32'(100 * (n / 2) + (n % 2)));
    clearDst(0, 18);
    clearLog(0);
    applyStimulus(0);
    checkOutput("t1_busy", {31'b0, oBusy[0]}, 32'd1);
    waitDone(0, "t1");
    checkPass(0, 9, 2, 1'b0, "t1");

    // A start pulse in RUN must change nothing.
    $display("[TB] test 4: start ignored in RUN");
    clearDst(0, 18);
    clearLog(0);
    applyStimulus(0);
    tick();
    tick();
    setStart(0, 1'b1);
    tick();
    setStart(0, 1'b0);
    waitDone(0, "t4");
    checkPass(0, 9, 2, 1'b0, "t4");

    // Restart from DONE with fresh random data.
    $display("[TB] test 5: restart from DONE");
    for (int n = 0; n < 18; n++) loadSrc(0, n, $urandom);
    clearDst(0, 18);
    clearLog(0);
    applyStimulus(0);
    checkOutput("t5_done_drop", {31'b0, oDone[0]}, 32'd0);
    checkOutput("t5_busy", {31'b0, oBusy[0]}, 32'd1);
    waitDone(0, "t5");
    checkPass(0, 9, 2, 1'b0, "t5");

    // Reset while the fifth write is pending.
    $display("[TB] test 3: reset mid-run");
    for (int n = 0; n < 18; n++) loadSrc(0, n, $urandom);
    clearDst(0, 18);
    clearLog(0);
    applyStimulus(0);
    guard = 0;
    while (wrCnt[0] < 4 && guard < 40) begin
      tick();
      guard++;
    end
    checkOutput("t3_fifth_pending", {31'b0, oWrEn[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t3_rst_addr_rd", oAddrRd[0], SRC);
    checkOutput("t3_rst_addr_wr", oAddrWr[0], 32'd0);
    checkOutput("t3_rst_wr_en", {31'b0, oWrEn[0]}, 32'd0);
    checkOutput("t3_rst_busy", {31'b0, oBusy[0]}, 32'd0);
    checkOutput("t3_rst_done", {31'b0, oDone[0]}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("t3_no_more_writes", 32'(wrCnt[0]), 32'd4);
    for (int n = 0; n < 18; n++) loadSrc(0, n, $urandom);
    clearDst(0, 18);
    clearLog(0);
    applyStimulus(0);
    waitDone(0, "t3b");
    checkPass(0, 9, 2, 1'b0, "t3b");

    // ReLU with Y(p,k) = odd p ? -p : p, then random signed data.
    $display("[TB] test 2: ReLU");
    for (int n = 0; n < 18; n++) begin
      if ((n / 2) % 2 == 1) loadSrc(1, n, -32'(n / 2));
      else                  loadSrc(1, n, 32'(n / 2));
    end
    clearDst(1, 18);
    clearLog(1);
    applyStimulus(1);
    waitDone(1, "t2");
    checkPass(1, 9, 2, 1'b1, "t2");
    for (int n = 0; n < 18; n++) begin
      checkOutput($sformatf("t2_src%0d", n), mem[1][idx(SRC + 32'(n))], srcVal[1][n]);
    end
    for (int n = 0; n < 18; n++) loadSrc(1, n, $urandom);
    clearDst(1, 18);
    clearLog(1);
    applyStimulus(1);
    waitDone(1, "t2r");
    checkPass(1, 9, 2, 1'b1, "t2r");

    // 1x1 map, one channel.
    $display("[TB] test 6: single word");
    loadSrc(2, 0, $urandom);
    clearDst(2, 1);
    clearLog(2);
    applyStimulus(2);
    waitDone(2, "t6");
    checkPass(2, 1, 1, 1'b0, "t6");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
